seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display scanner for N common-anode digits. It contains a one-hot active-low anode ring with a configurable slot length, and inserts anti-ghosting blank time between digits. It provides PWM brightness, a per-digit enable mask, leading-zero suppression, hex-to-segment decoding and tear-free frame snapshots. It sits between the value-formatting logic and the board's an/seg/dp pins.

---
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scanner with PWM brightness
// One-hot active-low anode ring, dead time, leading-zero blanking and per-frame snapshot.
module seg_scan_ctrl #(
   parameter int N_DIGITS    = 4,
   parameter int DIGIT_TICKS = 100000,
   parameter int BLANK_TICKS = 500,
   parameter int BRIGHT_W    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [4*N_DIGITS-1:0]       digits_in,
   input  logic [N_DIGITS-1:0]         dp_in,
   input  logic [N_DIGITS-1:0]         digit_en,
   input  logic                        lz_suppress,
   input  logic [BRIGHT_W-1:0]         brightness,
   output logic [N_DIGITS-1:0]         an,
   output logic [6:0]                  seg,
   output logic                        dp,
   output logic                        frame_start,
   output logic [$clog2(N_DIGITS)-1:0] cur_digit
);

   localparam int ON_TICKS = DIGIT_TICKS - BLANK_TICKS;
   localparam int CHUNK    = ON_TICKS >> BRIGHT_W;
   localparam int KW       = $clog2(DIGIT_TICKS);
   localparam int CW       = $clog2(N_DIGITS);

   if (BLANK_TICKS >= DIGIT_TICKS || (ON_TICKS % (2 ** BRIGHT_W)) != 0) begin : g_bad_params
      $error("seg_scan_ctrl: ON_TICKS must be a non-zero multiple of 2**BRIGHT_W");
   end

   logic [KW-1:0]           r_k;
   logic [CW-1:0]           r_cur;
   logic [4*N_DIGITS-1:0]   r_dig_snap;
   logic [N_DIGITS-1:0]     r_dp_snap;
   logic [N_DIGITS-1:0]     r_en_snap;
   logic                    r_lz_snap;
   logic [BRIGHT_W-1:0]     r_b_lat;

   logic                    w_first;
   logic                    w_frame;
   logic [4*N_DIGITS-1:0]   w_dig;
   logic [N_DIGITS-1:0]     w_dp;
   logic [N_DIGITS-1:0]     w_den;
   logic                    w_lz;
   logic [BRIGHT_W-1:0]     w_b;
   logic [3:0]              w_nib;
   logic                    w_upper_zero;
   logic                    w_lit;
   logic [31:0]             w_k32;
   logic [31:0]             w_on_end;
   logic                    w_on;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'h0: seg_decode = 7'b1000000;
         4'h1: seg_decode = 7'b1111001;
         4'h2: seg_decode = 7'b0100100;
         4'h3: seg_decode = 7'b0110000;
         4'h4: seg_decode = 7'b0011001;
         4'h5: seg_decode = 7'b0010010;
         4'h6: seg_decode = 7'b0000010;
         4'h7: seg_decode = 7'b1111000;
         4'h8: seg_decode = 7'b0000000;
         4'h9: seg_decode = 7'b0010000;
         4'hA: seg_decode = 7'b0001000;
         4'hB: seg_decode = 7'b0000011;
         4'hC: seg_decode = 7'b1000110;
         4'hD: seg_decode = 7'b0100001;
         4'hE: seg_decode = 7'b0000110;
         default: seg_decode = 7'b0001110;
      endcase
   endfunction

   // At slot start the values being latched this cycle are used directly, so BLANK_TICKS=0 still works.
   always_comb begin
      w_first  = (r_k == '0);
      w_frame  = w_first && (r_cur == '0);
      w_dig    = w_frame ? digits_in   : r_dig_snap;
      w_dp     = w_frame ? dp_in       : r_dp_snap;
      w_den    = w_frame ? digit_en    : r_en_snap;
      w_lz     = w_frame ? lz_suppress : r_lz_snap;
      w_b      = w_first ? brightness  : r_b_lat;
      w_nib    = w_dig[4*r_cur +: 4];
      w_upper_zero = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (CW'(i) >= r_cur && w_dig[4*i +: 4] != 4'h0) w_upper_zero = 1'b0;
      end
      w_lit    = w_den[r_cur] && !(w_lz && (r_cur != '0) && w_upper_zero);
      w_k32    = 32'(r_k);
      w_on_end = 32'(BLANK_TICKS) + 32'(CHUNK) * (32'(w_b) + 32'd1);
      w_on     = w_lit && (w_k32 >= 32'(BLANK_TICKS)) && (w_k32 < w_on_end);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k         <= '0;
         r_cur       <= '0;
         r_dig_snap  <= '0;
         r_dp_snap   <= '0;
         r_en_snap   <= '0;
         r_lz_snap   <= 1'b0;
         r_b_lat     <= '0;
         an          <= '1;
         seg         <= 7'h7F;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         an          <= '1;
         seg         <= 7'h7F;
         dp          <= 1'b1;
         frame_start <= 1'b0;
         if (en) begin
            if (w_first) begin
               r_b_lat <= brightness;
               if (r_cur == '0) begin
                  r_dig_snap  <= digits_in;
                  r_dp_snap   <= dp_in;
                  r_en_snap   <= digit_en;
                  r_lz_snap   <= lz_suppress;
                  frame_start <= 1'b1;
               end
            end
            if (w_on) begin
               an  <= ~(N_DIGITS'(1) << r_cur);
               seg <= seg_decode(w_nib);
               dp  <= ~w_dp[r_cur];
            end
            if (r_k == KW'(DIGIT_TICKS - 1)) begin
               r_k   <= '0;
               r_cur <= (r_cur == CW'(N_DIGITS - 1)) ? '0 : r_cur + 1'b1;
            end else begin
               r_k <= r_k + 1'b1;
            end
         end
      end
   end

   assign cur_digit = r_cur;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl against a per-cycle reference model
module tb_seg_scan_ctrl;

   localparam int N   = 4;
   localparam int DT  = 20;
   localparam int BT  = 4;
   localparam int BW  = 2;
   localparam int CHK = (DT - BT) >> BW;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [15:0]   digits_in;
   logic [3:0]    dp_in;
   logic [3:0]    digit_en;
   logic          lz_suppress;
   logic [BW-1:0] brightness;
   logic [3:0]    an;
   logic [6:0]    seg;
   logic          dp;
   logic          frame_start;
   logic [1:0]    cur_digit;

   seg_scan_ctrl #(.N_DIGITS(N), .DIGIT_TICKS(DT), .BLANK_TICKS(BT), .BRIGHT_W(BW)) dut (
      .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
      .digit_en(digit_en), .lz_suppress(lz_suppress), .brightness(brightness),
      .an(an), .seg(seg), .dp(dp), .frame_start(frame_start), .cur_digit(cur_digit)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
      logic [1:0] cur;
   } exp_t;

   exp_t q[$];
   int   vectors    = 0;
   int   miscompares = 0;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110 };

   int          m_k, m_cur, m_blat;
   logic [15:0] s_dig;
   logic [3:0]  s_dp, s_en;
   logic        s_lz;

   // Predicts what the DUT shows after the coming edge, queues it, then advances the model.
   task automatic step();
      exp_t e;
      bit   lit;
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0, cur: 2'd0};
      if (rst) begin
         m_k = 0; m_cur = 0; m_blat = 0;
         s_dig = '0; s_dp = '0; s_en = '0; s_lz = 1'b0;
      end else if (en) begin
         if (m_k == 0) begin
            m_blat = int'(brightness);
            if (m_cur == 0) begin
               s_dig = digits_in; s_dp = dp_in; s_en = digit_en; s_lz = lz_suppress;
               e.fs = 1'b1;
            end
         end
         lit = s_en[m_cur];
         if (s_lz && m_cur != 0) begin
            bit all_zero = 1'b1;
            for (int j = m_cur; j < N; j++) if (s_dig[4*j +: 4] != 4'h0) all_zero = 1'b0;
            if (all_zero) lit = 1'b0;
         end
         if (lit && m_k >= BT && m_k < BT + CHK * (m_blat + 1)) begin
            e.an[m_cur] = 1'b0;
            e.seg = seg_tab[s_dig[4*m_cur +: 4]];
            e.dp  = ~s_dp[m_cur];
         end
         m_k++;
         if (m_k == DT) begin
            m_k = 0;
            m_cur = (m_cur + 1) % N;
         end
      end
      e.cur = 2'(m_cur);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            vectors++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_start !== e.fs || cur_digit !== e.cur) begin
               miscompares++;
               $display("FAIL scan vec %0d t=%0t: got an=%b seg=%b dp=%b fs=%b cur=%0d, expected an=%b seg=%b dp=%b fs=%b cur=%0d",
                        vectors, $time, an, seg, dp, frame_start, cur_digit, e.an, e.seg, e.dp, e.fs, e.cur);
            end
            vectors++;
            if ($countones(~an) > 1) begin
               miscompares++;
               $display("FAIL an_onehot t=%0t: got an=%b, expected at most one low bit", $time, an);
            end
         end
      end
   end

   function automatic logic [15:0] rand_digits();
      logic [15:0] d;
      for (int j = 0; j < 4; j++) d[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      return d;
   endfunction

   initial begin : stimulus
      rst = 1'b1; en = 1'b0; digits_in = '0; dp_in = '0; digit_en = '0;
      lz_suppress = 1'b0; brightness = '0;
      repeat (3) step();

      rst = 1'b0; en = 1'b1; digits_in = 16'h1234; brightness = 2'd3; digit_en = 4'hF;
      repeat (200) step();
      brightness = 2'd0;
      repeat (90) step();
      brightness = 2'd2;
      repeat (50) step();
      digits_in = 16'hABCD;
      repeat (170) step();

      lz_suppress = 1'b1; digits_in = 16'h0005; repeat (100) step();
      digits_in = 16'h0000; repeat (90) step();
      digits_in = 16'h0105; dp_in = 4'b0101; repeat (90) step();
      lz_suppress = 1'b0; digit_en = 4'b1010; repeat (90) step();
      digit_en = 4'b0000; repeat (90) step();
      digit_en = 4'hF; brightness = 2'd3;
      repeat (9) step();
      en = 1'b0; repeat (7) step();
      en = 1'b1; repeat (60) step();
      rst = 1'b1; step();
      rst = 1'b0; repeat (40) step();

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 29) == 0) digits_in = rand_digits();
         if ($urandom_range(0, 39) == 0) brightness = BW'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) dp_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) digit_en = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 79) == 0) lz_suppress = 1'($urandom_range(0, 1));
         en  = ($urandom_range(0, 15) != 0);
         rst = ($urandom_range(0, 599) == 0);
         step();
      end
      rst = 1'b0;
      repeat (3) step();

      repeat (4) @(posedge clk);
      #3;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
